// File: rtl/decode_stage_if.sv
`timescale 1ns/1ps
// decode_stage_if: instruction-in and decoded-entry-out channels of the decode stage.
// The master modport is the environment side (producer upstream, consumer downstream).
// The slave modport is the decode stage itself.
interface decode_stage_if #(
   parameter int WORD_SIZE     = 9,
   parameter int OPCODE_SIZE   = 3,
   parameter int REG_ADDR_SIZE = 2
);
   localparam int SMALL_IMM_SIZE = WORD_SIZE - OPCODE_SIZE - 2*REG_ADDR_SIZE;
   localparam int BIG_IMM_SIZE   = REG_ADDR_SIZE + SMALL_IMM_SIZE;

   logic                          in_valid;
   logic                          in_ready;
   logic [2*WORD_SIZE-1:0]        in_instr;

   logic                          out_valid;
   logic                          out_ready;
   logic [2*OPCODE_SIZE-1:0]      out_opcode;
   logic [2*REG_ADDR_SIZE-1:0]    out_reg_dest;
   logic [2*REG_ADDR_SIZE-1:0]    out_reg_src;
   logic [2*SMALL_IMM_SIZE-1:0]   out_small_imm;
   logic [2*BIG_IMM_SIZE-1:0]     out_big_imm;
   logic                          out_is_alu;
   logic                          out_illegal;
   logic [15:0]                   decode_count;

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_opcode, out_reg_dest, out_reg_src,
             out_small_imm, out_big_imm, out_is_alu, out_illegal, decode_count
   );

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_opcode, out_reg_dest, out_reg_src,
             out_small_imm, out_big_imm, out_is_alu, out_illegal, decode_count
   );
endinterface

// File: rtl/decode_stage.sv
`timescale 1ns/1ps
// decode_stage: ternary instruction decoder behind a 2-entry skid buffer.
// Trit encoding: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 = invalid.
// Opcode numbering: opcode trits read MS first as base-3 digits (00->0, 01->1, 10->2);
// values 0..10 are the ALU ops, 11..18 the remaining defined ops, 19..26 are undefined.
// Optional macro TRIT_CHECK_EN: also flags an entry illegal when any trit of the
// instruction is 2'b11.
module decode_stage #(
   parameter int WORD_SIZE     = 9,
   parameter int OPCODE_SIZE   = 3,
   parameter int REG_ADDR_SIZE = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   decode_stage_if.slave  bus
);
   localparam int SMALL_IMM_SIZE = WORD_SIZE - OPCODE_SIZE - 2*REG_ADDR_SIZE;
   localparam int BIG_IMM_SIZE   = REG_ADDR_SIZE + SMALL_IMM_SIZE;
   localparam int OPW = 2*OPCODE_SIZE;
   localparam int RW  = 2*REG_ADDR_SIZE;
   localparam int SW  = 2*SMALL_IMM_SIZE;

   if (SMALL_IMM_SIZE < 1) begin : g_size_check
      $error("decode_stage: WORD_SIZE too small to hold a small immediate");
   end

   localparam logic [OPW-1:0] OP_NOT   = OPW'(6'b00_00_00);
   localparam logic [OPW-1:0] OP_AND   = OPW'(6'b00_00_01);
   localparam logic [OPW-1:0] OP_OR    = OPW'(6'b00_00_10);
   localparam logic [OPW-1:0] OP_XOR   = OPW'(6'b00_01_00);
   localparam logic [OPW-1:0] OP_ADD   = OPW'(6'b00_01_01);
   localparam logic [OPW-1:0] OP_SUB   = OPW'(6'b00_01_10);
   localparam logic [OPW-1:0] OP_COMP  = OPW'(6'b00_10_00);
   localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b00_10_01);
   localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b00_10_10);
   localparam logic [OPW-1:0] OP_SRI   = OPW'(6'b01_00_00);
   localparam logic [OPW-1:0] OP_SLI   = OPW'(6'b01_00_01);
   localparam logic [OPW-1:0] OP_LUI   = OPW'(6'b01_00_10);
   localparam logic [OPW-1:0] OP_LI    = OPW'(6'b01_01_00);
   localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b01_01_01);
   localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b01_01_10);
   localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b01_10_00);
   localparam logic [OPW-1:0] OP_JALR  = OPW'(6'b01_10_01);
   localparam logic [OPW-1:0] OP_LOAD  = OPW'(6'b01_10_10);
   localparam logic [OPW-1:0] OP_STORE = OPW'(6'b10_00_00);

   typedef struct packed {
      logic [OPW-1:0] opcode;
      logic [RW-1:0]  reg_dest;
      logic [RW-1:0]  reg_src;
      logic [SW-1:0]  small_imm;
      logic           is_alu;
      logic           illegal;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t      state, state_next;
   entry_t      dec, main_q, skid_q;
   logic        in_ready_q;
   logic [15:0] count_q;
   logic        load_main, load_skid, move_skid;
   logic        in_hs, out_hs;

   assign in_hs  = bus.in_valid && in_ready_q;
   assign out_hs = (state != EMPTY) && bus.out_ready;

   // Split the incoming word into fields and classify its opcode.
   always_comb begin
      dec = '0;
      {dec.opcode, dec.reg_dest, dec.reg_src, dec.small_imm} = bus.in_instr;
      case (dec.opcode)
         OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_COMP,
         OP_ANDI, OP_ADDI, OP_SRI, OP_SLI: dec.is_alu = 1'b1;
         OP_LUI, OP_LI, OP_BEQ, OP_BNE, OP_JAL, OP_JALR,
         OP_LOAD, OP_STORE: dec.is_alu = 1'b0;
         default: dec.illegal = 1'b1;
      endcase
`ifdef TRIT_CHECK_EN
      for (int i = 0; i < WORD_SIZE; i++) begin
         if (bus.in_instr[2*i +: 2] == 2'b11) begin
            dec.illegal = 1'b1;
         end
      end
`endif
   end

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Next occupancy and which register each accepted or drained entry moves into.
   always_comb begin
      state_next = state;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      move_skid  = 1'b0;
      unique case (state)
         EMPTY: begin
            if (in_hs) begin
               state_next = ONE;
               load_main  = 1'b1;
            end
         end
         ONE: begin
            if (in_hs && !bus.out_ready) begin
               state_next = FULL;
               load_skid  = 1'b1;
            end else if (in_hs) begin
               load_main  = 1'b1;
            end else if (bus.out_ready) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (bus.out_ready) begin
               state_next = ONE;
               move_skid  = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   // Entry registers, registered ready and the delivered-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
         count_q    <= '0;
      end else begin
         in_ready_q <= (state_next != FULL);
         if (load_main) begin
            main_q <= dec;
         end else if (move_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= dec;
         end
         if (out_hs) begin
            count_q <= count_q + 16'd1;
         end
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = (state != EMPTY);
   assign bus.out_opcode    = main_q.opcode;
   assign bus.out_reg_dest  = main_q.reg_dest;
   assign bus.out_reg_src   = main_q.reg_src;
   assign bus.out_small_imm = main_q.small_imm;
   assign bus.out_big_imm   = {main_q.reg_src, main_q.small_imm};
   assign bus.out_is_alu    = main_q.is_alu;
   assign bus.out_illegal   = main_q.illegal;
   assign bus.decode_count  = count_q;

endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
// tb_decode_stage: scoreboard bench for decode_stage with default parameters.
// Accepted instructions are decoded by a trit-level reference model and queued;
// a negedge monitor pops the queue on every output handshake.
module tb_decode_stage;
   logic clk;
   logic rst_n;

   decode_stage_if #(.WORD_SIZE(9), .OPCODE_SIZE(3), .REG_ADDR_SIZE(2)) bus();

   decode_stage #(.WORD_SIZE(9), .OPCODE_SIZE(3), .REG_ADDR_SIZE(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [5:0] opcode;
      logic [3:0] reg_dest;
      logic [3:0] reg_src;
      logic [3:0] small_imm;
      logic [7:0] big_imm;
      logic       is_alu;
      logic       illegal;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_exp;
   exp_t        held;
   logic [27:0] cur_entry;
   logic [15:0] exp_count;
   logic        armed;
   logic        stalled;
   logic        acc;
   int          assert_count;
   int          fail_count;
   int          out_seen;
   int          seen_mark;

   assign cur_entry = {bus.out_opcode, bus.out_reg_dest, bus.out_reg_src, bus.out_small_imm,
                       bus.out_big_imm, bus.out_is_alu, bus.out_illegal};

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so a stuck run still ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference decode from the trit rules: base-3 opcode value, field extraction by arithmetic.
   function automatic exp_t model(input logic [17:0] instr);
      exp_t e;
      int   w, op, idx, t;
      bit   bad;
      w   = int'(instr);
      op  = w / 4096;
      e.small_imm = 4'(w % 16);
      e.reg_src   = 4'((w / 16) % 16);
      e.reg_dest  = 4'((w / 256) % 16);
      e.opcode    = 6'(op);
      e.big_imm   = 8'(w % 256);
      idx = 0;
      bad = 1'b0;
      for (int k = 2; k >= 0; k--) begin
         t = (op / (4 ** k)) % 4;
         if (t == 3) bad = 1'b1;
         idx = idx * 3 + t;
      end
      e.illegal = bad || (idx >= 19);
      e.is_alu  = !bad && (idx <= 10);
`ifdef TRIT_CHECK_EN
      for (int k = 0; k < 9; k++) begin
         if (((w / (4 ** k)) % 4) == 3) e.illegal = 1'b1;
      end
`endif
      return e;
   endfunction

   function automatic logic [1:0] rand_trit(input bit allow_bad);
      if (allow_bad && ($urandom_range(0, 11) == 0)) return 2'b11;
      return 2'($urandom_range(0, 2));
   endfunction

   function automatic logic [3:0] rand_reg();
      return {rand_trit(1'b0), rand_trit(1'b0)};
   endfunction

   function automatic logic [17:0] rand_instr();
      logic [17:0] v;
      for (int k = 0; k < 9; k++) v[2*k +: 2] = rand_trit(1'b1);
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One cycle of stimulus, entered and left 1 ns after a rising edge.
   task automatic applyStimulus(input logic v, input logic [17:0] instr, input logic rdy,
                                output logic accepted);
      bus.in_valid  = v;
      bus.in_instr  = instr;
      bus.out_ready = rdy;
      @(negedge clk);
      accepted = v && bus.in_ready;
      @(posedge clk);
      if (accepted) exp_q.push_back(model(instr));
      #1;
   endtask

   // Load one instruction, leave it on the outputs for direct inspection.
   task automatic loadOne(input logic [17:0] instr);
      logic a;
      applyStimulus(1'b1, instr, 1'b0, a);
      bus.in_valid = 1'b0;
      checkOutput("load_one_accept", 64'(a), 64'd1);
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 18'd0, 1'b1, a);
   endtask

   // Ready only rises on the first edge with reset released.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed <= 1'b0;
      else        armed <= 1'b1;
   end

   // Monitor: occupancy-derived handshake checks, stability, and in-order entry compare.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_count = 16'd0;
         stalled   = 1'b0;
      end else begin
         checkOutput("in_ready", 64'(bus.in_ready), 64'(armed && (exp_q.size() < 2)));
         checkOutput("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
         checkOutput("decode_count", 64'(bus.decode_count), 64'(exp_count));
         if (stalled && bus.out_valid) checkOutput("stable_while_stalled", 64'(cur_entry), 64'(held));
         stalled = bus.out_valid && !bus.out_ready;
         held    = exp_t'(cur_entry);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_output", 64'd1, 64'd0);
            end else begin
               mon_exp = exp_q.pop_front();
               checkOutput("entry", 64'(cur_entry), 64'(mon_exp));
            end
            exp_count = exp_count + 16'd1;
            out_seen++;
         end
      end
   end

   initial begin
      assert_count  = 0;
      fail_count    = 0;
      out_seen      = 0;
      exp_count     = 16'd0;
      stalled       = 1'b0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 18'd0;
      bus.out_ready = 1'b0;

      // Reset values.
      #2;
      checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("reset_count", 64'(bus.decode_count), 64'd0);
      checkOutput("reset_fields", 64'(cur_entry), 64'd0);
      #10 rst_n = 1'b1;
      @(posedge clk) #1;
      checkOutput("ready_after_release", 64'(bus.in_ready), 64'd1);

      // Streaming: 8 back-to-back ADDs with the consumer always ready.
      seen_mark = out_seen;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, {6'b00_01_01, rand_reg(), rand_reg(), rand_reg()}, 1'b1, acc);
         checkOutput("stream_accept", 64'(acc), 64'd1);
      end
      idle(2);
      checkOutput("stream_outputs", 64'(out_seen - seen_mark), 64'd8);
      checkOutput("stream_count", 64'(bus.decode_count), 64'd8);

      // Backpressure: only two fit, the third is refused.
      seen_mark = out_seen;
      applyStimulus(1'b1, {6'b00_00_01, 4'b0001, 4'b0010, 4'b0100}, 1'b0, acc);
      checkOutput("bp_accept_0", 64'(acc), 64'd1);
      applyStimulus(1'b1, {6'b00_00_10, 4'b1000, 4'b0101, 4'b1010}, 1'b0, acc);
      checkOutput("bp_accept_1", 64'(acc), 64'd1);
      checkOutput("bp_full_ready", 64'(bus.in_ready), 64'd0);
      applyStimulus(1'b1, {6'b00_01_00, 4'b1001, 4'b0110, 4'b0000}, 1'b0, acc);
      checkOutput("bp_accept_2", 64'(acc), 64'd0);
      idle(3);
      checkOutput("bp_drained_outputs", 64'(out_seen - seen_mark), 64'd2);
      checkOutput("bp_ready_again", 64'(bus.in_ready), 64'd1);

      // Field packing: reg_src = (+1,-1), small_imm = (0,+1).
      loadOne({6'b00_10_10, 4'b00_01, 4'b01_10, 4'b00_01});
      checkOutput("field_big_imm", 64'(bus.out_big_imm), 64'h61);
      checkOutput("field_reg_src", 64'(bus.out_reg_src), 64'b0110);
      checkOutput("field_small_imm", 64'(bus.out_small_imm), 64'b0001);
      checkOutput("field_reg_dest", 64'(bus.out_reg_dest), 64'b0001);
      idle(1);

      // Opcode classification corners.
      loadOne({6'b10_00_10, 12'd0});
      checkOutput("undef_op_illegal", 64'(bus.out_illegal), 64'd1);
      checkOutput("undef_op_is_alu", 64'(bus.out_is_alu), 64'd0);
      idle(1);
      loadOne({6'b11_00_00, 12'd0});
      checkOutput("bad_trit_op_illegal", 64'(bus.out_illegal), 64'd1);
      idle(1);
      loadOne({6'b01_00_01, 12'd0});
      checkOutput("sli_is_alu", 64'(bus.out_is_alu), 64'd1);
      checkOutput("sli_illegal", 64'(bus.out_illegal), 64'd0);
      idle(1);
      loadOne({6'b01_00_10, 12'd0});
      checkOutput("lui_is_alu", 64'(bus.out_is_alu), 64'd0);
      checkOutput("lui_illegal", 64'(bus.out_illegal), 64'd0);
      idle(1);
      loadOne({6'b00_01_01, 4'b0001, 4'b0001, 4'b11_00});
`ifdef TRIT_CHECK_EN
      checkOutput("add_bad_imm_illegal", 64'(bus.out_illegal), 64'd1);
`else
      checkOutput("add_bad_imm_illegal", 64'(bus.out_illegal), 64'd0);
`endif
      checkOutput("add_bad_imm_is_alu", 64'(bus.out_is_alu), 64'd1);
      idle(1);

      // Random traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 9) < 7), rand_instr(), 1'($urandom_range(0, 1)), acc);
      end
      idle(3);

      // Reset while holding two entries.
      applyStimulus(1'b1, rand_instr(), 1'b0, acc);
      applyStimulus(1'b1, rand_instr(), 1'b0, acc);
      checkOutput("pre_reset_full", 64'(bus.in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      #1;
      checkOutput("mid_reset_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("mid_reset_count", 64'(bus.decode_count), 64'd0);
      checkOutput("mid_reset_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("mid_reset_fields", 64'(cur_entry), 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk) #1;
      checkOutput("ready_after_mid_reset", 64'(bus.in_ready), 64'd1);

      // Counter wrap after 65535 deliveries.
      for (int i = 0; i < 65535; i++) begin
         applyStimulus(1'b1, rand_instr(), 1'b1, acc);
      end
      idle(2);
      checkOutput("count_at_max", 64'(bus.decode_count), 64'hFFFF);
      applyStimulus(1'b1, rand_instr(), 1'b1, acc);
      idle(2);
      checkOutput("count_wrapped", 64'(bus.decode_count), 64'd0);

      checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end
endmodule
